grid_env_step: RTL and testbench

- Environment/action stage directly upstream of the episode control unit.
- Holds the agent's current cell on a 5x5 grid and picks an action each step: epsilon-greedy, with a 16-bit LFSR as the random source.
- Applies the move and registers next_state plus reward.
- next_state feeds the control unit, where code 25 marks the terminal/goal.
- Consumes change_iteration (episode restart) and done (training finished) from the control unit.

---
 rtl/q_learn_pkg.sv | 20 ++
 rtl/grid_env_step_grid_move.sv | 44 ++++
 rtl/grid_env_step.sv | 108 ++++++++++
 tb/tb_grid_env_step.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_learn_pkg.sv
// Shared types and constants for the Q-learning grid environment.
package q_learn_pkg;

  localparam int unsigned GRID_DIM   = 5;
  localparam int unsigned NUM_STATES = 25;

  typedef logic [4:0]        state_t;
  typedef logic signed [7:0] reward_t;

  // Code 25 sits just past the last cell and marks the absorbing goal.
  localparam state_t TERMINAL_STATE = 5'd25;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_RIGHT = 2'd1,
    ACT_DOWN  = 2'd2,
    ACT_LEFT  = 2'd3
  } action_e;

endpackage

// File: rtl/grid_env_step_grid_move.sv
// Combinational move generator: (cur_state, action) -> (candidate, off_grid).
// When the move leaves the grid the candidate is the current cell.
module grid_move
  import q_learn_pkg::*;
(
  input  logic [4:0] cur_state,
  input  logic [1:0] action,
  output logic [4:0] candidate,
  output logic       off_grid
);

  localparam logic [4:0] Dim  = 5'(GRID_DIM);
  localparam logic [4:0] Last = 5'(GRID_DIM - 1);

  logic [4:0] row;
  logic [4:0] col;

  // Decode row/column and pick the neighbouring cell for the requested action.
  always_comb begin
    row       = cur_state / Dim;
    col       = cur_state % Dim;
    candidate = cur_state;
    off_grid  = 1'b0;
    unique case (action_e'(action))
      ACT_UP: begin
        if (row == 5'd0) off_grid = 1'b1;
        else             candidate = cur_state - Dim;
      end
      ACT_RIGHT: begin
        if (col == Last) off_grid = 1'b1;
        else             candidate = cur_state + 5'd1;
      end
      ACT_DOWN: begin
        if (row == Last) off_grid = 1'b1;
        else             candidate = cur_state + Dim;
      end
      ACT_LEFT: begin
        if (col == 5'd0) off_grid = 1'b1;
        else             candidate = cur_state - 5'd1;
      end
    endcase
  end

endmodule

// File: rtl/grid_env_step.sv
// 5x5 grid environment step: epsilon-greedy action pick from a 16-bit Galois
// LFSR, move/reward evaluation, registered step result with a one-cycle strobe.
// Optional obstacle checking is enabled by defining GRID_ENV_OBSTACLE_EN.
module grid_env_step
  import q_learn_pkg::*;
#(
  parameter logic [4:0]        START_STATE   = 5'd0,
  parameter logic [4:0]        GOAL_STATE    = 5'd24,
  parameter logic [24:0]       OBSTACLE_MASK = 25'h0041040,
  parameter logic signed [7:0] REWARD_GOAL   = 8'sd100,
  parameter logic signed [7:0] REWARD_WALL   = -8'sd10,
  parameter logic signed [7:0] REWARD_STEP   = -8'sd1,
  parameter logic [15:0]       LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       act_valid,
  input  logic [1:0] greedy_action,
  input  logic [7:0] epsilon_in,
  input  logic       change_iteration,
  input  logic       done,
  output logic [4:0] state_out,
  output logic [1:0] action_out,
  output logic [4:0] next_state,
  output logic [7:0] reward,
  output logic       out_valid
);

  state_t      cur_state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [1:0]  action;
  logic [4:0]  candidate;
  logic        off_grid;
  logic        blocked;
  state_t      move_state;
  logic [7:0]  move_reward;
  logic        accept;

  // Epsilon-greedy pick and LFSR successor (taps x^16+x^14+x^13+x^11+1).
  always_comb begin
    action    = (lfsr[7:0] < epsilon_in) ? lfsr[9:8] : greedy_action;
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  grid_move u_grid_move (
    .cur_state (cur_state),
    .action    (action),
    .candidate (candidate),
    .off_grid  (off_grid)
  );

`ifdef GRID_ENV_OBSTACLE_EN
  assign blocked = off_grid | OBSTACLE_MASK[candidate];
`else
  // Mask is deliberately ignored in this build; only grid edges block.
  logic unused_obstacle_mask;
  assign unused_obstacle_mask = ^OBSTACLE_MASK;
  assign blocked = off_grid;
`endif

  // Resolve the move into the resulting cell and its reward.
  always_comb begin
    move_state  = cur_state;
    move_reward = REWARD_WALL;
    if (!blocked) begin
      if (candidate == GOAL_STATE) begin
        move_state  = TERMINAL_STATE;
        move_reward = REWARD_GOAL;
      end else begin
        move_state  = candidate;
        move_reward = REWARD_STEP;
      end
    end
  end

  assign accept = act_valid && !done && !change_iteration && (cur_state != TERMINAL_STATE);

  // Step register: rst > done > change_iteration > accepted step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= START_STATE;
      state_out  <= 5'd0;
      action_out <= 2'd0;
      next_state <= START_STATE;
      reward     <= 8'd0;
      out_valid  <= 1'b0;
      lfsr       <= LFSR_SEED;
    end else if (done) begin
      out_valid <= 1'b0;
    end else if (change_iteration) begin
      cur_state  <= START_STATE;
      next_state <= START_STATE;
      out_valid  <= 1'b0;
    end else if (accept) begin
      cur_state  <= move_state;
      state_out  <= cur_state;
      action_out <= action;
      next_state <= move_state;
      reward     <= move_reward;
      out_valid  <= 1'b1;
      lfsr       <= lfsr_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grid_env_step.sv
// Directed self-checking bench for grid_env_step.
module tb_grid_env_step;

  logic       clk = 1'b0;
  logic       rst;
  logic       act_valid;
  logic [1:0] greedy_action;
  logic [7:0] epsilon_in;
  logic       change_iteration;
  logic       done;
  logic [4:0] state_out;
  logic [1:0] action_out;
  logic [4:0] next_state;
  logic [7:0] reward;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [24:0] ObsMask = 25'h0041040;

  // Reference state kept by the bench.
  logic [15:0] m_lfsr;
  logic [4:0]  m_cur;
  logic [4:0]  e_state;
  logic [1:0]  e_act;
  logic [4:0]  e_next;
  logic [7:0]  e_rew;

  always #5 clk = ~clk;

  grid_env_step dut (
    .clk              (clk),
    .rst              (rst),
    .act_valid        (act_valid),
    .greedy_action    (greedy_action),
    .epsilon_in       (epsilon_in),
    .change_iteration (change_iteration),
    .done             (done),
    .state_out        (state_out),
    .action_out       (action_out),
    .next_state       (next_state),
    .reward           (reward),
    .out_valid        (out_valid)
  );

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic void model_move(input logic [4:0] cur, input logic [1:0] act,
                                     output logic [4:0] nxt, output logic [7:0] rew);
    int r, c, n;
    logic wall;
    r = int'(cur) / 5;
    c = int'(cur) % 5;
    n = int'(cur);
    wall = 1'b0;
    case (act)
      2'd0: if (r == 0) wall = 1'b1; else n = n - 5;
      2'd1: if (c == 4) wall = 1'b1; else n = n + 1;
      2'd2: if (r == 4) wall = 1'b1; else n = n + 5;
      default: if (c == 0) wall = 1'b1; else n = n - 1;
    endcase
`ifdef GRID_ENV_OBSTACLE_EN
    if (!wall && ObsMask[n]) wall = 1'b1;
`endif
    if (wall) begin
      nxt = cur;
      rew = 8'hF6;
    end else if (n == 24) begin
      nxt = 5'd25;
      rew = 8'h64;
    end else begin
      nxt = 5'(n);
      rew = 8'hFF;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    act_valid = 1'b0; change_iteration = 1'b0; done = 1'b0; rst = 1'b0;
  endtask

  // Greedy step with hand-computed expectations; advances the reference LFSR.
  task automatic greedy_step(input string nm, input logic [1:0] g, input logic [4:0] es,
                             input logic [4:0] en, input logic [7:0] er);
    epsilon_in = 8'd0; greedy_action = g; act_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || state_out !== es || action_out !== g || next_state !== en
        || reward !== er) begin
      errors++;
      $display("FAIL %s: got v=%0b s=%0d a=%0d n=%0d r=%0h want v=1 s=%0d a=%0d n=%0d r=%0h",
               nm, out_valid, state_out, action_out, next_state, reward, es, g, en, er);
    end
    m_lfsr = lfsr_adv(m_lfsr);
    m_cur = en;
    act_valid = 1'b0;
  endtask

  // Exploring step checked against the reference LFSR and grid model.
  task automatic model_step(input string nm);
    logic [1:0] act;
    logic [4:0] nx;
    logic [7:0] rw;
    epsilon_in = 8'hFF; greedy_action = 2'd1; act_valid = 1'b1;
    act = (m_lfsr[7:0] < 8'hFF) ? m_lfsr[9:8] : 2'd1;
    tick();
    checks++;
    if (m_cur == 5'd25) begin
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s: got out_valid=%0b want 0 at terminal", nm, out_valid);
      end
    end else begin
      model_move(m_cur, act, nx, rw);
      if (out_valid !== 1'b1 || state_out !== m_cur || action_out !== act || next_state !== nx
          || reward !== rw) begin
        errors++;
        $display("FAIL %s: got v=%0b s=%0d a=%0d n=%0d r=%0h want v=1 s=%0d a=%0d n=%0d r=%0h",
                 nm, out_valid, state_out, action_out, next_state, reward, m_cur, act, nx, rw);
      end
      e_state = m_cur; e_act = act; e_next = nx; e_rew = rw;
      m_lfsr = lfsr_adv(m_lfsr);
      m_cur = nx;
    end
    act_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; act_valid = 1'b1; greedy_action = 2'd1; epsilon_in = 8'd0;
    tick();
    rst = 1'b0; act_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || state_out !== 5'd0 || action_out !== 2'd0 || next_state !== 5'd0
        || reward !== 8'd0) begin
      errors++;
      $display("FAIL reset: got v=%0b s=%0d a=%0d n=%0d r=%0h want all zero",
               out_valid, state_out, action_out, next_state, reward);
    end
    m_lfsr = 16'hACE1;
    m_cur = 5'd0;
  endtask

  task automatic test_wall();
    greedy_step("wall_up", 2'd0, 5'd0, 5'd0, 8'hF6);
    tick();
    checks++;
    if (out_valid !== 1'b0 || next_state !== 5'd0 || reward !== 8'hF6) begin
      errors++;
      $display("FAIL strobe_hold: got v=%0b n=%0d r=%0h want v=0 n=0 r=f6",
               out_valid, next_state, reward);
    end
  endtask

  task automatic test_first_step();
    greedy_step("step_right", 2'd1, 5'd0, 5'd1, 8'hFF);
  endtask

  task automatic test_obstacle();
`ifdef GRID_ENV_OBSTACLE_EN
    greedy_step("obstacle_down", 2'd2, 5'd1, 5'd1, 8'hF6);
`else
    greedy_step("no_obstacle_down", 2'd2, 5'd1, 5'd6, 8'hFF);
`endif
    change_iteration = 1'b1;
    tick();
    change_iteration = 1'b0;
    m_cur = 5'd0;
    checks++;
    if (out_valid !== 1'b0 || next_state !== 5'd0) begin
      errors++;
      $display("FAIL restart: got v=%0b n=%0d want v=0 n=0", out_valid, next_state);
    end
  endtask

  task automatic test_goal();
    greedy_step("down_5", 2'd2, 5'd0, 5'd5, 8'hFF);
    greedy_step("down_10", 2'd2, 5'd5, 5'd10, 8'hFF);
    greedy_step("down_15", 2'd2, 5'd10, 5'd15, 8'hFF);
    greedy_step("down_20", 2'd2, 5'd15, 5'd20, 8'hFF);
    greedy_step("wall_down_row4", 2'd2, 5'd20, 5'd20, 8'hF6);
    greedy_step("right_21", 2'd1, 5'd20, 5'd21, 8'hFF);
    greedy_step("right_22", 2'd1, 5'd21, 5'd22, 8'hFF);
    greedy_step("right_23", 2'd1, 5'd22, 5'd23, 8'hFF);
    greedy_step("goal", 2'd1, 5'd23, 5'd25, 8'h64);
    // Terminal is absorbing: requests are ignored and outputs hold.
    act_valid = 1'b1; greedy_action = 2'd3;
    tick(); tick();
    act_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || next_state !== 5'd25 || reward !== 8'h64) begin
      errors++;
      $display("FAIL terminal_ignore: got v=%0b n=%0d r=%0h want v=0 n=25 r=64",
               out_valid, next_state, reward);
    end
    change_iteration = 1'b1;
    tick();
    change_iteration = 1'b0;
    m_cur = 5'd0;
    checks++;
    if (out_valid !== 1'b0 || next_state !== 5'd0) begin
      errors++;
      $display("FAIL goal_restart: got v=%0b n=%0d want v=0 n=0", out_valid, next_state);
    end
    greedy_step("after_restart", 2'd1, 5'd0, 5'd1, 8'hFF);
  endtask

  task automatic test_restart_wins();
    greedy_step("right_2", 2'd1, 5'd1, 5'd2, 8'hFF);
    greedy_step("down_7", 2'd2, 5'd2, 5'd7, 8'hFF);
    change_iteration = 1'b1; act_valid = 1'b1; greedy_action = 2'd1; epsilon_in = 8'd0;
    tick();
    change_iteration = 1'b0; act_valid = 1'b0;
    m_cur = 5'd0;
    checks++;
    if (out_valid !== 1'b0 || next_state !== 5'd0) begin
      errors++;
      $display("FAIL restart_wins: got v=%0b n=%0d want v=0 n=0", out_valid, next_state);
    end
    greedy_step("from_start", 2'd0, 5'd0, 5'd0, 8'hF6);
  endtask

  task automatic test_explore();
    for (int i = 0; i < 20; i++) model_step($sformatf("explore_%0d", i));
  endtask

  task automatic test_done();
    change_iteration = 1'b1;
    tick();
    change_iteration = 1'b0;
    m_cur = 5'd0;
    model_step("pre_done");
    done = 1'b1; act_valid = 1'b1; change_iteration = 1'b1; epsilon_in = 8'hFF;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || state_out !== e_state || action_out !== e_act
        || next_state !== e_next || reward !== e_rew) begin
      errors++;
      $display("FAIL done_freeze: got v=%0b s=%0d a=%0d n=%0d r=%0h want v=0 s=%0d a=%0d n=%0d r=%0h",
               out_valid, state_out, action_out, next_state, reward, e_state, e_act, e_next,
               e_rew);
    end
    done = 1'b0; change_iteration = 1'b0; act_valid = 1'b0;
    model_step("post_done");
    model_step("post_done_2");
  endtask

  task automatic test_midrun_reset();
    model_step("pre_rst");
    rst = 1'b1; act_valid = 1'b1; change_iteration = 1'b1;
    tick();
    rst = 1'b0; act_valid = 1'b0; change_iteration = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || state_out !== 5'd0 || action_out !== 2'd0 || next_state !== 5'd0
        || reward !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset: got v=%0b s=%0d a=%0d n=%0d r=%0h want all zero",
               out_valid, state_out, action_out, next_state, reward);
    end
    m_lfsr = 16'hACE1;
    m_cur = 5'd0;
    model_step("seed_again_0");
    model_step("seed_again_1");
  endtask

  initial begin
    idle();
    greedy_action = 2'd0;
    epsilon_in = 8'd0;
    m_lfsr = 16'hACE1;
    m_cur = 5'd0;
    e_state = 5'd0; e_act = 2'd0; e_next = 5'd0; e_rew = 8'd0;
    #2;
    test_reset();
    test_wall();
    test_first_step();
    test_obstacle();
    test_goal();
    test_restart_wins();
    test_explore();
    test_done();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
